// File: rtl/sram_req_arbiter_pkg.sv
// Shared definitions for the SRAM request arbiter: source tags and FSM states.
package sram_req_arbiter_pkg;

  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  typedef enum logic {
    StIdle = 1'b0,
    StHold = 1'b1
  } state_e;

endpackage

// File: rtl/tag_fifo.sv
// Small 1-bit-wide synchronous FIFO that remembers which requester owns each
// outstanding memory transaction, in issue order.
module tag_fifo #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  logic push_tag_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output logic head_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  logic [DEPTH-1:0] mem_q;
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == FullCnt);
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_tag_i;
        wr_ptr_q        <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// Shares one SRAM-like port between fetch and data requesters: fixed priority to
// data with a starvation guard for fetch, in-order response routing by tag.
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int unsigned MAX_OUT      = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inst_req_i,
  input  logic [31:0] inst_addr_i,
  output logic        inst_addr_ok_o,
  output logic        inst_data_ok_o,
  output logic [31:0] inst_rdata_o,
  input  logic        data_req_i,
  input  logic        data_wr_i,
  input  logic [3:0]  data_wstrb_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_addr_ok_o,
  output logic        data_data_ok_o,
  output logic [31:0] data_rdata_o,
  output logic        mem_req_o,
  output logic        mem_wr_o,
  output logic [3:0]  mem_wstrb_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_addr_ok_i,
  input  logic        mem_data_ok_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned StarveW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);

  state_e             state_q;
  logic               grant_q;
  logic               grant_sel, grant;
  logic [StarveW-1:0] starve_q, starve_d;
  logic               q_full, q_empty, q_head;
  logic               issue, accept, pop;

  // Data normally wins; fetch wins once it has waited STARVE_LIMIT cycles.
  always_comb begin
    grant_sel = SRC_DATA;
    if (inst_req_i && (!data_req_i || (starve_q == StarveMax))) begin
      grant_sel = SRC_INST;
    end
  end

  assign grant  = (state_q == StHold) ? grant_q : grant_sel;
  assign issue  = (state_q == StHold) || (!q_full && (inst_req_i || data_req_i));
  assign accept = issue && mem_addr_ok_i;
  assign pop    = mem_data_ok_i && !q_empty;

  always_comb begin
    mem_req_o   = issue;
    mem_wr_o    = 1'b0;
    mem_wstrb_o = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (issue) begin
      if (grant == SRC_INST) begin
        mem_addr_o = inst_addr_i;
      end else begin
        mem_addr_o = data_addr_i;
        mem_wr_o   = data_wr_i;
        if (data_wr_i) begin
          mem_wstrb_o = data_wstrb_i;
          mem_wdata_o = data_wdata_i;
        end
      end
    end
  end

  assign inst_addr_ok_o = accept && (grant == SRC_INST);
  assign data_addr_ok_o = accept && (grant == SRC_DATA);
  assign inst_data_ok_o = pop && (q_head == SRC_INST);
  assign data_data_ok_o = pop && (q_head == SRC_DATA);
  assign inst_rdata_o   = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;

  always_comb begin
    starve_d = starve_q;
    if (!inst_req_i || inst_addr_ok_o) begin
      starve_d = '0;
    end else if (starve_q != StarveMax) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      grant_q  <= SRC_DATA;
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
      unique case (state_q)
        StIdle: begin
          if (issue && !mem_addr_ok_i) begin
            state_q <= StHold;
            grant_q <= grant_sel;
          end
        end
        StHold: begin
          if (mem_addr_ok_i) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  tag_fifo #(
    .DEPTH (MAX_OUT)
  ) u_tag_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (accept),
    .push_tag_i (grant),
    .pop_i      (pop),
    .full_o     (q_full),
    .empty_o    (q_empty),
    .head_o     (q_head)
  );

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Bench for sram_req_arbiter: directed scenarios plus a randomized run checked
// against a queue-based reference model.
module tb_sram_req_arbiter;

  localparam int unsigned MaxOut      = 2;
  localparam int unsigned StarveLimit = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = '0;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req = 1'b0;
  logic        data_wr = 1'b0;
  logic [3:0]  data_wstrb = '0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok = 1'b0;
  logic        mem_data_ok = 1'b0;
  logic [31:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_req_arbiter #(
    .MAX_OUT      (MaxOut),
    .STARVE_LIMIT (StarveLimit)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .inst_req_i     (inst_req),
    .inst_addr_i    (inst_addr),
    .inst_addr_ok_o (inst_addr_ok),
    .inst_data_ok_o (inst_data_ok),
    .inst_rdata_o   (inst_rdata),
    .data_req_i     (data_req),
    .data_wr_i      (data_wr),
    .data_wstrb_i   (data_wstrb),
    .data_addr_i    (data_addr),
    .data_wdata_i   (data_wdata),
    .data_addr_ok_o (data_addr_ok),
    .data_data_ok_o (data_data_ok),
    .data_rdata_o   (data_rdata),
    .mem_req_o      (mem_req),
    .mem_wr_o       (mem_wr),
    .mem_wstrb_o    (mem_wstrb),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .mem_addr_ok_i  (mem_addr_ok),
    .mem_data_ok_i  (mem_data_ok),
    .mem_rdata_i    (mem_rdata)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_wstrb = '0; data_addr = '0; data_wdata = '0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [141:0] outs;
    idle_inputs();
    rst = 1'b1;
    next_cycle();
    settle();
    outs = {mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata, inst_addr_ok, inst_data_ok,
            data_addr_ok, data_data_ok, inst_rdata, data_rdata};
    checks++;
    if (outs !== '0) begin
      errors++; $display("FAIL reset_cycle_outputs got %h want 0", outs);
    end
    next_cycle();
    rst = 1'b0;
    settle();
    outs = {mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata, inst_addr_ok, inst_data_ok,
            data_addr_ok, data_data_ok, inst_rdata, data_rdata};
    checks++;
    if (outs !== '0) begin
      errors++; $display("FAIL post_reset_outputs got %h want 0", outs);
    end
    next_cycle();
  endtask

  task automatic test_load();
    do_reset();
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h1C00_0040; mem_addr_ok = 1'b1;
    settle();
    checks++;
    if ({mem_req, data_addr_ok, inst_addr_ok} !== 3'b110) begin
      errors++; $display("FAIL load_accept got %b want 110", {mem_req, data_addr_ok, inst_addr_ok});
    end
    checks++;
    if ({mem_addr, mem_wr, mem_wstrb} !== {32'h1C00_0040, 1'b0, 4'b0000}) begin
      errors++; $display("FAIL load_payload got %h/%b/%b", mem_addr, mem_wr, mem_wstrb);
    end
    next_cycle();
    idle_inputs();
    next_cycle();
    mem_data_ok = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    settle();
    checks++;
    if ({data_data_ok, inst_data_ok, data_rdata} !== {2'b10, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL load_resp got dok=%b iok=%b rdata=%h want 1 0 deadbeef",
               data_data_ok, inst_data_ok, data_rdata);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_collision();
    do_reset();
    inst_req = 1'b1; inst_addr = 32'h1C00_0100;
    data_req = 1'b1; data_addr = 32'h1C00_0200;
    for (int i = 0; i < 5; i++) begin
      settle();
      checks++;
      if ({mem_req, mem_addr, inst_addr_ok, data_addr_ok} !== {1'b1, 32'h1C00_0200, 2'b00}) begin
        errors++;
        $display("FAIL collision_hold[%0d] got req=%b addr=%h ok=%b%b", i, mem_req, mem_addr,
                 inst_addr_ok, data_addr_ok);
      end
      next_cycle();
    end
    mem_addr_ok = 1'b1;
    settle();
    checks++;
    if ({inst_addr_ok, data_addr_ok} !== 2'b01) begin
      errors++; $display("FAIL collision_accept got %b%b want 01", inst_addr_ok, data_addr_ok);
    end
    next_cycle();
    data_addr = 32'h1C00_0300;
    settle();
    checks++;
    if ({inst_addr_ok, data_addr_ok, mem_addr} !== {2'b10, 32'h1C00_0100}) begin
      errors++;
      $display("FAIL collision_starved_inst got ok=%b%b addr=%h want 10 1c000100",
               inst_addr_ok, data_addr_ok, mem_addr);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_starvation();
    logic [1:0] exp_aok [6] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
    logic [1:0] exp_dok [6] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    do_reset();
    inst_req = 1'b1; inst_addr = 32'h0000_1000;
    data_req = 1'b1; data_addr = 32'h0000_2000;
    mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    for (int c = 0; c < 6; c++) begin
      mem_rdata = 32'h0000_0100 + c;
      settle();
      checks++;
      if ({inst_addr_ok, data_addr_ok} !== exp_aok[c]) begin
        errors++;
        $display("FAIL starve_addr_ok[%0d] got %b%b want %b", c, inst_addr_ok, data_addr_ok,
                 exp_aok[c]);
      end
      checks++;
      if ({inst_data_ok, data_data_ok} !== exp_dok[c]) begin
        errors++;
        $display("FAIL starve_data_ok[%0d] got %b%b want %b", c, inst_data_ok, data_data_ok,
                 exp_dok[c]);
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_order();
    do_reset();
    inst_req = 1'b1; inst_addr = 32'h1C00_0000; mem_addr_ok = 1'b1;
    settle();
    checks++;
    if (inst_addr_ok !== 1'b1) begin
      errors++; $display("FAIL order_inst_accept got %b want 1", inst_addr_ok);
    end
    next_cycle();
    inst_req = 1'b0; data_req = 1'b1; data_addr = 32'h1C00_0004;
    settle();
    checks++;
    if (data_addr_ok !== 1'b1) begin
      errors++; $display("FAIL order_data_accept got %b want 1", data_addr_ok);
    end
    next_cycle();
    data_req = 1'b0; inst_req = 1'b1; inst_addr = 32'h1C00_0008;
    mem_data_ok = 1'b1; mem_rdata = 32'h1111_1111;
    settle();
    checks++;
    if ({mem_req, inst_addr_ok} !== 2'b00) begin
      errors++; $display("FAIL order_full_block got req=%b aok=%b want 00", mem_req, inst_addr_ok);
    end
    checks++;
    if ({inst_data_ok, data_data_ok, inst_rdata} !== {2'b10, 32'h1111_1111}) begin
      errors++;
      $display("FAIL order_first_resp got %b%b %h want 10 11111111", inst_data_ok,
               data_data_ok, inst_rdata);
    end
    next_cycle();
    mem_rdata = 32'h2222_2222;
    settle();
    checks++;
    if ({inst_data_ok, data_data_ok, data_rdata} !== {2'b01, 32'h2222_2222}) begin
      errors++;
      $display("FAIL order_second_resp got %b%b %h want 01 22222222", inst_data_ok,
               data_data_ok, data_rdata);
    end
    checks++;
    if ({mem_req, inst_addr_ok, mem_addr} !== {2'b11, 32'h1C00_0008}) begin
      errors++;
      $display("FAIL order_issue_resume got req=%b aok=%b addr=%h", mem_req, inst_addr_ok,
               mem_addr);
    end
    next_cycle();
    inst_req = 1'b0; mem_addr_ok = 1'b0; mem_rdata = 32'h3333_3333;
    settle();
    checks++;
    if ({inst_data_ok, data_data_ok} !== 2'b10) begin
      errors++; $display("FAIL order_third_resp got %b%b want 10", inst_data_ok, data_data_ok);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_store();
    do_reset();
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'b0011;
    data_addr = 32'h1C00_0080; data_wdata = 32'h0000_ABCD; mem_addr_ok = 1'b1;
    settle();
    checks++;
    if ({mem_wr, mem_wstrb, mem_wdata, data_addr_ok} !== {1'b1, 4'b0011, 32'h0000_ABCD, 1'b1})
    begin
      errors++;
      $display("FAIL store_payload got wr=%b strb=%b wdata=%h aok=%b", mem_wr, mem_wstrb,
               mem_wdata, data_addr_ok);
    end
    next_cycle();
    idle_inputs();
    mem_data_ok = 1'b1;
    settle();
    checks++;
    if ({data_data_ok, inst_data_ok} !== 2'b10) begin
      errors++; $display("FAIL store_resp got %b%b want 10", data_data_ok, inst_data_ok);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_reset_hold();
    do_reset();
    data_req = 1'b1; data_addr = 32'h1C00_00C0; mem_addr_ok = 1'b1;
    next_cycle();
    data_req = 1'b0; mem_addr_ok = 1'b0; inst_req = 1'b1; inst_addr = 32'h1C00_0010;
    next_cycle();
    settle();
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h1C00_0010}) begin
      errors++; $display("FAIL hold_before_reset got req=%b addr=%h", mem_req, mem_addr);
    end
    next_cycle();
    idle_inputs();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    settle();
    checks++;
    if (mem_req !== 1'b0) begin
      errors++; $display("FAIL reset_drops_req got %b want 0", mem_req);
    end
    next_cycle();
    mem_data_ok = 1'b1; mem_rdata = 32'h5A5A_5A5A;
    settle();
    checks++;
    if ({inst_data_ok, data_data_ok, data_rdata} !== {2'b00, 32'h5A5A_5A5A}) begin
      errors++;
      $display("FAIL stray_resp got %b%b %h want 00 5a5a5a5a", inst_data_ok, data_data_ok,
               data_rdata);
    end
    next_cycle();
    idle_inputs();
  endtask

  // Reference: a tag queue, a wait counter for fetch and a locked winner while stalled.
  task automatic test_random(input int n);
    bit        q[$];
    int        starve = 0;
    bit        locked = 1'b0;
    bit        lock_w = 1'b0;
    bit        exp_req, w, exp_ia, exp_da, exp_pop, exp_idok, exp_ddok;
    logic [31:0] exp_addr;
    do_reset();
    for (int c = 0; c < n; c++) begin
      if (!inst_req && ($urandom_range(1, 0) == 1)) begin
        inst_req = 1'b1; inst_addr = $urandom;
      end
      if (!data_req && ($urandom_range(1, 0) == 1)) begin
        data_req = 1'b1; data_addr = $urandom; data_wr = 1'($urandom_range(1, 0));
        data_wstrb = 4'($urandom_range(15, 0)); data_wdata = $urandom;
      end
      mem_addr_ok = ($urandom_range(9, 0) < 6);
      mem_data_ok = (q.size() > 0) ? 1'($urandom_range(1, 0)) : ($urandom_range(19, 0) == 0);
      mem_rdata = $urandom;
      settle();
      if (locked) begin
        exp_req = 1'b1; w = lock_w;
      end else if ((q.size() < MaxOut) && (inst_req || data_req)) begin
        exp_req = 1'b1;
        w = (inst_req && (!data_req || starve == StarveLimit)) ? 1'b0 : 1'b1;
      end else begin
        exp_req = 1'b0; w = 1'b0;
      end
      exp_ia   = exp_req && mem_addr_ok && !w;
      exp_da   = exp_req && mem_addr_ok && w;
      exp_pop  = mem_data_ok && (q.size() > 0);
      exp_idok = exp_pop && (q[0] == 1'b0);
      exp_ddok = exp_pop && (q[0] == 1'b1);
      checks++;
      if (mem_req !== exp_req) begin
        errors++; $display("FAIL rnd_mem_req[%0d] got %b want %b", c, mem_req, exp_req);
      end
      if (exp_req) begin
        exp_addr = w ? data_addr : inst_addr;
        checks++;
        if ({mem_addr, mem_wr, mem_wstrb} !==
            {exp_addr, w && data_wr, (w && data_wr) ? data_wstrb : 4'b0000}) begin
          errors++;
          $display("FAIL rnd_payload[%0d] got %h/%b/%b want addr %h", c, mem_addr, mem_wr,
                   mem_wstrb, exp_addr);
        end
        if (w && data_wr) begin
          checks++;
          if (mem_wdata !== data_wdata) begin
            errors++; $display("FAIL rnd_wdata[%0d] got %h want %h", c, mem_wdata, data_wdata);
          end
        end
      end
      checks++;
      if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !==
          {exp_ia, exp_da, exp_idok, exp_ddok}) begin
        errors++;
        $display("FAIL rnd_oks[%0d] got %b%b%b%b want %b%b%b%b", c, inst_addr_ok, data_addr_ok,
                 inst_data_ok, data_data_ok, exp_ia, exp_da, exp_idok, exp_ddok);
      end
      checks++;
      if ({inst_rdata, data_rdata} !== {mem_rdata, mem_rdata}) begin
        errors++; $display("FAIL rnd_rdata[%0d] got %h %h want %h", c, inst_rdata, data_rdata,
                           mem_rdata);
      end
      if (exp_pop) void'(q.pop_front());
      if (exp_req && mem_addr_ok) q.push_back(w);
      locked = exp_req && !mem_addr_ok;
      lock_w = w;
      if (!inst_req || exp_ia) starve = 0;
      else if (starve < StarveLimit) starve++;
      next_cycle();
      if (exp_ia) inst_req = 1'b0;
      if (exp_da) data_req = 1'b0;
    end
    idle_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load();
    test_collision();
    test_starvation();
    test_order();
    test_store();
    test_reset_hold();
    test_random(1500);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
